imem_read_arbiter: RTL and testbench



---
 rtl/imem_read_arbiter_if.sv | 39 +++
 rtl/imem_read_arbiter.sv | 92 +++++++++
 tb/tb_imem_read_arbiter.sv | 359 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_read_arbiter_if.sv
// Bus bundle for the instruction-memory read arbiter: two requester ports
// (fetch F, debug D), the memory-side address/data pair and the grant counters.
interface imem_read_arbiter_if;
    logic        f_req_valid;
    logic [31:0] f_req_addr;
    logic        f_req_ready;
    logic        f_rsp_valid;
    logic [31:0] f_rsp_instr;
    logic        f_rsp_err;

    logic        d_req_valid;
    logic [31:0] d_req_addr;
    logic        d_req_ready;
    logic        d_rsp_valid;
    logic [31:0] d_rsp_instr;
    logic        d_rsp_err;

    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;

    logic [15:0] f_grant_cnt;
    logic [15:0] d_grant_cnt;

    // Arbiter side
    modport slave (
        input  f_req_valid, f_req_addr, d_req_valid, d_req_addr, mem_rdata,
        output f_req_ready, f_rsp_valid, f_rsp_instr, f_rsp_err,
        output d_req_ready, d_rsp_valid, d_rsp_instr, d_rsp_err,
        output mem_addr, f_grant_cnt, d_grant_cnt
    );

    // Requester / memory-model side
    modport master (
        output f_req_valid, f_req_addr, d_req_valid, d_req_addr, mem_rdata,
        input  f_req_ready, f_rsp_valid, f_rsp_instr, f_rsp_err,
        input  d_req_ready, d_rsp_valid, d_rsp_instr, d_rsp_err,
        input  mem_addr, f_grant_cnt, d_grant_cnt
    );
endinterface

// File: rtl/imem_read_arbiter.sv
// Two-port read arbiter in front of the combinational-read instruction memory.
// Fetch (F) has priority; debug (D) is forced through after STARVE_LIMIT
// consecutive losses. Read data is registered and returned to the granted
// port one cycle after the grant, with misaligned/out-of-range flagged.
module imem_read_arbiter #(
    parameter int IDX_LO       = 2,
    parameter int IDX_HI       = 11,
    parameter int STARVE_LIMIT = 4
) (
    input logic               Clk,
    input logic               Rst_n,
    imem_read_arbiter_if.slave bus
);
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {OWN_NONE, OWN_F, OWN_D} owner_e;

    owner_e      owner_q, owner_d;
    logic [31:0] data_q,  data_d;
    logic        err_q,   err_d;
    logic [3:0]  starve_q, starve_d;
    logic [15:0] fcnt_q,  fcnt_d;
    logic [15:0] dcnt_q,  dcnt_d;

    logic        f_gnt, d_gnt;
    logic [31:0] gnt_addr;
    logic        gnt_err;

    // Grant selection: F wins unless D has hit its starvation limit.
    // Held off while reset is asserted so every output reads 0 in reset.
    always_comb begin
        f_gnt    = Rst_n && bus.f_req_valid &&
                   !(bus.d_req_valid && (starve_q == LIMIT));
        d_gnt    = Rst_n && bus.d_req_valid && !f_gnt;
        gnt_addr = f_gnt ? bus.f_req_addr : (d_gnt ? bus.d_req_addr : 32'd0);
        // Sub-word offset bits must be clear, and nothing above the word index.
        gnt_err  = (|gnt_addr[IDX_LO-1:0]) || (|gnt_addr[31:IDX_HI+1]);
    end

    // Next-state: response capture, starvation tracking, saturating counters.
    always_comb begin
        owner_d = OWN_NONE;
        data_d  = 32'd0;
        err_d   = 1'b0;
        if (f_gnt || d_gnt) begin
            owner_d = f_gnt ? OWN_F : OWN_D;
            err_d   = gnt_err;
            data_d  = gnt_err ? 32'd0 : bus.mem_rdata;
        end

        starve_d = 4'd0;
        if (bus.d_req_valid && !d_gnt)
            starve_d = (starve_q == LIMIT) ? starve_q : starve_q + 4'd1;

        fcnt_d = (f_gnt && fcnt_q != 16'hFFFF) ? fcnt_q + 16'd1 : fcnt_q;
        dcnt_d = (d_gnt && dcnt_q != 16'hFFFF) ? dcnt_q + 16'd1 : dcnt_q;
    end

    // State registers; reset discards any in-flight response.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            owner_q  <= OWN_NONE;
            data_q   <= 32'd0;
            err_q    <= 1'b0;
            starve_q <= 4'd0;
            fcnt_q   <= 16'd0;
            dcnt_q   <= 16'd0;
        end else begin
            owner_q  <= owner_d;
            data_q   <= data_d;
            err_q    <= err_d;
            starve_q <= starve_d;
            fcnt_q   <= fcnt_d;
            dcnt_q   <= dcnt_d;
        end
    end

    assign bus.f_req_ready = f_gnt;
    assign bus.d_req_ready = d_gnt;
    assign bus.mem_addr    = gnt_addr;

    // Only the owner of the response register sees it; the other port reads 0.
    assign bus.f_rsp_valid = (owner_q == OWN_F);
    assign bus.f_rsp_instr = (owner_q == OWN_F) ? data_q : 32'd0;
    assign bus.f_rsp_err   = (owner_q == OWN_F) && err_q;
    assign bus.d_rsp_valid = (owner_q == OWN_D);
    assign bus.d_rsp_instr = (owner_q == OWN_D) ? data_q : 32'd0;
    assign bus.d_rsp_err   = (owner_q == OWN_D) && err_q;

    assign bus.f_grant_cnt = fcnt_q;
    assign bus.d_grant_cnt = dcnt_q;
endmodule

// File: tb/tb_imem_read_arbiter.sv
// Bench for imem_read_arbiter: directed scenarios plus a randomized run, all
// checked against a cycle-level reference model of the arbitration rules.
module tb_imem_read_arbiter;
    localparam int LIMIT = 4;

    logic Clk = 1'b0;
    logic Rst_n;
    always #5 Clk = ~Clk;

    imem_read_arbiter_if bus();

    imem_read_arbiter #(.IDX_LO(2), .IDX_HI(11), .STARVE_LIMIT(LIMIT)) dut (
        .Clk  (Clk),
        .Rst_n(Rst_n),
        .bus  (bus)
    );

    // Memory model: word i holds i*3.
    assign bus.mem_rdata = {22'd0, bus.mem_addr[11:2]} * 32'd3;

    int checks = 0;
    int failures = 0;

    // Reference model state
    int          m_owner;      // 0 none, 1 F, 2 D
    logic [31:0] m_data;
    logic        m_err;
    int          m_loss;       // consecutive cycles D has been refused
    int          m_fcnt, m_dcnt;

    // Current-cycle stimulus and predictions
    logic        c_fv, c_dv;
    logic [31:0] c_fa, c_da;
    logic        e_fg, e_dg;
    logic [31:0] e_maddr;

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        return 32'(((a >> 2) % 1024) * 3);
    endfunction

    function automatic logic ref_err(input logic [31:0] a);
        return (a % 4 != 0) || (a >= 32'd4096);
    endfunction

    task automatic model_reset();
        m_owner = 0; m_data = 0; m_err = 0; m_loss = 0; m_fcnt = 0; m_dcnt = 0;
    endtask

    // Drive one cycle's requests in the low phase and predict the grant.
    task automatic apply(input logic fv, input logic [31:0] fa,
                         input logic dv, input logic [31:0] da);
        @(negedge Clk);
        bus.f_req_valid = fv; bus.f_req_addr = fa;
        bus.d_req_valid = dv; bus.d_req_addr = da;
        c_fv = fv; c_fa = fa; c_dv = dv; c_da = da;
        // D takes the slot when alone, or once it has lost LIMIT times in a row.
        e_dg = dv && (!fv || m_loss >= LIMIT);
        e_fg = fv && !e_dg;
        e_maddr = e_fg ? fa : (e_dg ? da : 32'd0);
        #1;
    endtask

    // Advance the model to what the coming rising edge must produce.
    task automatic commit();
        logic [31:0] a;
        if (e_fg || e_dg) begin
            a = e_fg ? c_fa : c_da;
            m_owner = e_fg ? 1 : 2;
            m_err = ref_err(a);
            m_data = m_err ? 32'd0 : ref_word(a);
        end else begin
            m_owner = 0; m_data = 0; m_err = 0;
        end
        if (e_fg && m_fcnt < 65535) m_fcnt++;
        if (e_dg && m_dcnt < 65535) m_dcnt++;
        if (c_dv && !e_dg) m_loss = (m_loss < LIMIT) ? m_loss + 1 : LIMIT;
        else m_loss = 0;
    endtask

    task automatic reset_dut();
        @(negedge Clk);
        bus.f_req_valid = 0; bus.d_req_valid = 0;
        bus.f_req_addr = 0; bus.d_req_addr = 0;
        Rst_n = 1'b0;
        model_reset();
        @(negedge Clk);
        Rst_n = 1'b1;
    endtask

    task automatic test_reset();
        // Power-on reset state
        checks++;
        if ({bus.f_rsp_valid, bus.d_rsp_valid, bus.f_rsp_err, bus.d_rsp_err,
             bus.f_req_ready, bus.d_req_ready} !== 6'd0) begin
            failures++; $display("FAIL reset_flags: got %b expected 000000",
                {bus.f_rsp_valid, bus.d_rsp_valid, bus.f_rsp_err, bus.d_rsp_err,
                 bus.f_req_ready, bus.d_req_ready});
        end
        checks++;
        if ({bus.f_grant_cnt, bus.d_grant_cnt} !== 32'd0) begin
            failures++; $display("FAIL reset_cnt: got %h expected 0",
                {bus.f_grant_cnt, bus.d_grant_cnt});
        end
        @(negedge Clk); Rst_n = 1'b1;
        model_reset();

        // Create a pending F response, then reset in the middle of it
        apply(1, 32'h20, 0, 0); commit();
        @(posedge Clk); #2;
        checks++;
        if (bus.f_rsp_valid !== 1'b1 || bus.f_rsp_instr !== 32'h18) begin
            failures++; $display("FAIL reset_pending: got v=%b d=%h expected v=1 d=18",
                bus.f_rsp_valid, bus.f_rsp_instr);
        end
        bus.f_req_valid = 0; bus.d_req_valid = 0;
        Rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({bus.f_rsp_valid, bus.d_rsp_valid, bus.f_rsp_err, bus.d_rsp_err} !== 4'd0 ||
            bus.f_rsp_instr !== 32'd0 || bus.d_rsp_instr !== 32'd0) begin
            failures++; $display("FAIL reset_async_rsp: got v=%b instr=%h expected 0",
                bus.f_rsp_valid, bus.f_rsp_instr);
        end
        checks++;
        if (bus.f_grant_cnt !== 16'd0 || bus.mem_addr !== 32'd0) begin
            failures++; $display("FAIL reset_async_cnt: got cnt=%h addr=%h expected 0",
                bus.f_grant_cnt, bus.mem_addr);
        end
        @(negedge Clk); Rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            apply(0, 0, 0, 0);
            checks++;
            if (bus.f_rsp_valid !== 1'b0 || bus.d_rsp_valid !== 1'b0) begin
                failures++; $display("FAIL reset_no_rsp: got f=%b d=%b expected 0 0",
                    bus.f_rsp_valid, bus.d_rsp_valid);
            end
            commit();
        end
    endtask

    task automatic test_single_f();
        reset_dut();
        apply(1, 32'h10, 0, 0);
        checks++;
        if (bus.f_req_ready !== 1'b1 || bus.d_req_ready !== 1'b0 || bus.mem_addr !== 32'h10) begin
            failures++; $display("FAIL single_grant: got fr=%b dr=%b addr=%h expected 1 0 10",
                bus.f_req_ready, bus.d_req_ready, bus.mem_addr);
        end
        commit();
        apply(0, 0, 0, 0);
        checks++;
        if (bus.f_rsp_valid !== 1'b1 || bus.f_rsp_instr !== 32'h0000000C || bus.f_rsp_err !== 1'b0) begin
            failures++; $display("FAIL single_rsp: got v=%b d=%h e=%b expected 1 0000000c 0",
                bus.f_rsp_valid, bus.f_rsp_instr, bus.f_rsp_err);
        end
        checks++;
        if (bus.d_rsp_valid !== 1'b0) begin
            failures++; $display("FAIL single_d_quiet: got %b expected 0", bus.d_rsp_valid);
        end
        commit();
        apply(0, 0, 0, 0);
        checks++;
        if (bus.f_rsp_valid !== 1'b0) begin
            failures++; $display("FAIL single_pulse: got %b expected 0", bus.f_rsp_valid);
        end
        commit();
    endtask

    task automatic test_contention();
        reset_dut();
        for (int i = 0; i < 10; i++) begin
            apply(1, 32'h40, 1, 32'h80);
            checks++;
            if (bus.d_req_ready !== (i % 5 == 4) || bus.f_req_ready !== (i % 5 != 4)) begin
                failures++; $display("FAIL contention_cycle%0d: got fr=%b dr=%b expected fr=%b dr=%b",
                    i, bus.f_req_ready, bus.d_req_ready, i % 5 != 4, i % 5 == 4);
            end
            commit();
        end
        apply(0, 0, 0, 0);
        checks++;
        if (bus.d_rsp_valid !== 1'b1 || bus.d_rsp_instr !== 32'h60) begin
            failures++; $display("FAIL contention_rsp: got v=%b d=%h expected 1 60",
                bus.d_rsp_valid, bus.d_rsp_instr);
        end
        checks++;
        if (bus.f_grant_cnt !== 16'd8 || bus.d_grant_cnt !== 16'd2) begin
            failures++; $display("FAIL contention_cnt: got f=%0d d=%0d expected 8 2",
                bus.f_grant_cnt, bus.d_grant_cnt);
        end
        commit();
    endtask

    task automatic test_errors();
        reset_dut();
        apply(1, 32'h6, 0, 0); commit();
        apply(0, 0, 1, 32'h1000);
        checks++;
        if (bus.f_rsp_err !== 1'b1 || bus.f_rsp_instr !== 32'd0 || bus.f_rsp_valid !== 1'b1) begin
            failures++; $display("FAIL err_misaligned: got v=%b e=%b d=%h expected 1 1 0",
                bus.f_rsp_valid, bus.f_rsp_err, bus.f_rsp_instr);
        end
        checks++;
        if (bus.f_grant_cnt !== 16'd1 || bus.d_req_ready !== 1'b1) begin
            failures++; $display("FAIL err_f_cnt: got cnt=%0d dr=%b expected 1 1",
                bus.f_grant_cnt, bus.d_req_ready);
        end
        commit();
        apply(0, 0, 0, 0);
        checks++;
        if (bus.d_rsp_err !== 1'b1 || bus.d_rsp_instr !== 32'd0 || bus.f_rsp_err !== 1'b0) begin
            failures++; $display("FAIL err_range: got de=%b d=%h fe=%b expected 1 0 0",
                bus.d_rsp_err, bus.d_rsp_instr, bus.f_rsp_err);
        end
        checks++;
        if (bus.d_grant_cnt !== 16'd1) begin
            failures++; $display("FAIL err_d_cnt: got %0d expected 1", bus.d_grant_cnt);
        end
        commit();
    endtask

    task automatic test_d_drop();
        reset_dut();
        for (int i = 0; i < 3; i++) begin
            apply(1, 32'h40, 1, 32'h80);
            checks++;
            if (bus.d_req_ready !== 1'b0) begin
                failures++; $display("FAIL drop_pre%0d: got dr=%b expected 0", i, bus.d_req_ready);
            end
            commit();
        end
        apply(1, 32'h40, 0, 0); commit();
        for (int k = 0; k < 5; k++) begin
            apply(1, 32'h40, 1, 32'h84);
            checks++;
            if (bus.d_req_ready !== (k == 4)) begin
                failures++; $display("FAIL drop_post%0d: got dr=%b expected %b",
                    k, bus.d_req_ready, k == 4);
            end
            commit();
        end
        apply(0, 0, 0, 0); commit();
    endtask

    task automatic test_back_to_back();
        reset_dut();
        // F then D on consecutive cycles; responses arrive in grant order.
        apply(1, 32'h8, 0, 0); commit();
        apply(0, 0, 1, 32'hC);
        checks++;
        if (bus.f_rsp_valid !== 1'b1 || bus.f_rsp_instr !== 32'h6 || bus.d_rsp_valid !== 1'b0) begin
            failures++; $display("FAIL b2b_first: got fv=%b f=%h dv=%b expected 1 6 0",
                bus.f_rsp_valid, bus.f_rsp_instr, bus.d_rsp_valid);
        end
        commit();
        apply(0, 0, 0, 0);
        checks++;
        if (bus.d_rsp_valid !== 1'b1 || bus.d_rsp_instr !== 32'h9 || bus.f_rsp_valid !== 1'b0) begin
            failures++; $display("FAIL b2b_second: got dv=%b d=%h fv=%b expected 1 9 0",
                bus.d_rsp_valid, bus.d_rsp_instr, bus.f_rsp_valid);
        end
        commit();
    endtask

    task automatic test_random();
        logic pf, pd;
        logic [31:0] fa, da;
        pf = 0; pd = 0; fa = 0; da = 0;
        reset_dut();
        for (int i = 0; i < 400; i++) begin
            if (!pf && $urandom_range(0, 3) != 0) begin
                pf = 1;
                fa = $urandom_range(0, 1023) * 4;
                if ($urandom_range(0, 7) == 0) fa = fa | $urandom_range(1, 3);
                if ($urandom_range(0, 7) == 0) fa = fa | (32'h1000 << $urandom_range(0, 19));
            end
            if (!pd && $urandom_range(0, 2) != 0) begin
                pd = 1;
                da = $urandom_range(0, 1023) * 4;
                if ($urandom_range(0, 7) == 0) da = da | $urandom_range(1, 3);
                if ($urandom_range(0, 7) == 0) da = da | (32'h1000 << $urandom_range(0, 19));
            end
            apply(pf, fa, pd, da);
            checks++;
            if (bus.f_req_ready !== e_fg || bus.d_req_ready !== e_dg || bus.mem_addr !== e_maddr) begin
                failures++; $display("FAIL rand_grant@%0d: got fr=%b dr=%b a=%h expected %b %b %h",
                    i, bus.f_req_ready, bus.d_req_ready, bus.mem_addr, e_fg, e_dg, e_maddr);
            end
            checks++;
            if (bus.f_rsp_valid !== (m_owner == 1) ||
                bus.f_rsp_instr !== ((m_owner == 1) ? m_data : 32'd0) ||
                bus.f_rsp_err !== ((m_owner == 1) && m_err)) begin
                failures++; $display("FAIL rand_f_rsp@%0d: got v=%b d=%h e=%b expected v=%b d=%h e=%b",
                    i, bus.f_rsp_valid, bus.f_rsp_instr, bus.f_rsp_err,
                    m_owner == 1, (m_owner == 1) ? m_data : 32'd0, (m_owner == 1) && m_err);
            end
            checks++;
            if (bus.d_rsp_valid !== (m_owner == 2) ||
                bus.d_rsp_instr !== ((m_owner == 2) ? m_data : 32'd0) ||
                bus.d_rsp_err !== ((m_owner == 2) && m_err)) begin
                failures++; $display("FAIL rand_d_rsp@%0d: got v=%b d=%h e=%b expected v=%b d=%h e=%b",
                    i, bus.d_rsp_valid, bus.d_rsp_instr, bus.d_rsp_err,
                    m_owner == 2, (m_owner == 2) ? m_data : 32'd0, (m_owner == 2) && m_err);
            end
            checks++;
            if (bus.f_grant_cnt !== 16'(m_fcnt) || bus.d_grant_cnt !== 16'(m_dcnt)) begin
                failures++; $display("FAIL rand_cnt@%0d: got f=%0d d=%0d expected %0d %0d",
                    i, bus.f_grant_cnt, bus.d_grant_cnt, m_fcnt, m_dcnt);
            end
            commit();
            if (e_fg) pf = 0;
            if (e_dg) pd = 0;
        end
        apply(0, 0, 0, 0); commit();
    endtask

    task automatic test_saturation();
        reset_dut();
        @(negedge Clk);
        bus.f_req_valid = 1; bus.f_req_addr = 0; bus.d_req_valid = 0;
        repeat (65540) @(posedge Clk);
        m_fcnt = 65535; m_owner = 1; m_data = 0; m_err = 0; m_loss = 0;
        apply(1, 0, 0, 0);
        checks++;
        if (bus.f_grant_cnt !== 16'hFFFF) begin
            failures++; $display("FAIL sat_hold: got %h expected ffff", bus.f_grant_cnt);
        end
        commit();
        apply(0, 0, 0, 0);
        checks++;
        if (bus.f_grant_cnt !== 16'hFFFF || bus.d_grant_cnt !== 16'd0) begin
            failures++; $display("FAIL sat_nowrap: got f=%h d=%h expected ffff 0000",
                bus.f_grant_cnt, bus.d_grant_cnt);
        end
        commit();
    endtask

    initial begin
        Rst_n = 1'b1;
        bus.f_req_valid = 0; bus.f_req_addr = 0;
        bus.d_req_valid = 0; bus.d_req_addr = 0;
        c_fv = 0; c_dv = 0; c_fa = 0; c_da = 0;
        e_fg = 0; e_dg = 0; e_maddr = 0;
        model_reset();
        #1 Rst_n = 1'b0;
        #2;
        test_reset();
        test_single_f();
        test_contention();
        test_errors();
        test_d_drop();
        test_back_to_back();
        test_random();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
